// File: rtl/bids_n_auction_pkg.sv
// Shared types and codes for the sealed-bid auction controller.
package bids_n_auction_pkg;

  // Host control opcodes; encodings 7..15 are rejected as invalid.
  typedef enum logic [3:0] {
    OpNoOp      = 4'd0,
    OpUnlock    = 4'd1,
    OpLock      = 4'd2,
    OpLoadBal   = 4'd3,
    OpSetMask   = 4'd4,
    OpSetTimer  = 4'd5,
    OpBidCharge = 4'd6
  } op_e;

  typedef enum logic [2:0] {
    StUnlocked,
    StLocked,
    StLockout,
    StRound,
    StResult
  } state_e;

  // Controller error codes.
  localparam logic [2:0] ErrNone          = 3'b000;
  localparam logic [2:0] ErrBadKey        = 3'b001;
  localparam logic [2:0] ErrAlreadyUnlock = 3'b010;
  localparam logic [2:0] ErrStartUnlocked = 3'b011;
  localparam logic [2:0] ErrBadOp         = 3'b100;
  localparam logic [2:0] ErrDupTop        = 3'b101;

  // Per-bidder error codes.
  localparam logic [1:0] BErrNone     = 2'b00;
  localparam logic [1:0] BErrInactive = 2'b01;
  localparam logic [1:0] BErrFunds    = 2'b10;
  localparam logic [1:0] BErrMasked   = 2'b11;

endpackage

// File: rtl/bids_n_auction_if.sv
// Host and bidder-facing signal bundle of the auction controller.
interface bids_n_auction_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned BID_W = 16,
  parameter int unsigned BAL_W = 32
);
  logic [N-1:0]       bid;
  logic [N-1:0]       retract;
  logic [N*BID_W-1:0] bid_amt;
  logic               C_start;
  logic [3:0]         C_op;
  logic [BAL_W-1:0]   C_data;
  logic [3:0]         C_idx;

  logic [N-1:0]       ack;
  logic [N-1:0]       win;
  logic [2*N-1:0]     b_err;
  logic [N*BAL_W-1:0] balance;
  logic [2:0]         err;
  logic               ready;
  logic               roundOver;
  logic [BID_W-1:0]   maxBid;

  // Host plus bidder agents.
  modport master (
    output bid, retract, bid_amt, C_start, C_op, C_data, C_idx,
    input  ack, win, b_err, balance, err, ready, roundOver, maxBid
  );

  // Auction controller.
  modport slave (
    input  bid, retract, bid_amt, C_start, C_op, C_data, C_idx,
    output ack, win, b_err, balance, err, ready, roundOver, maxBid
  );
endinterface

// File: rtl/bids_n_auction_max_select.sv
// Combinational argmax over N packed unsigned values; zero entries never win.
module bids_n_auction_max_select #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 16
) (
  input  logic [N*W-1:0] vals_i,
  output logic [W-1:0]   max_o,
  output logic [N-1:0]   onehot_o,
  output logic           dup_o,
  output logic           any_o
);

  logic [W-1:0] best;
  logic [N-1:0] best_oh;
  logic         seen;
  logic         dup;

  // Strict compare keeps the lowest index on ties and skips zeros.
  always_comb begin
    best    = '0;
    best_oh = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vals_i[i*W +: W] > best) begin
        best       = vals_i[i*W +: W];
        best_oh    = '0;
        best_oh[i] = 1'b1;
      end
    end
  end

  // Flag when a second nonzero entry also equals the maximum.
  always_comb begin
    seen = 1'b0;
    dup  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if ((best != '0) && (vals_i[i*W +: W] == best)) begin
        if (seen) dup = 1'b1;
        seen = 1'b1;
      end
    end
  end

  assign max_o    = best;
  assign onehot_o = best_oh;
  assign dup_o    = dup;
  assign any_o    = (best != '0);

endmodule

// File: rtl/bids_n_auction.sv
// N-bidder sealed-bid auction controller with key lock, lockout timer and balance debit.
module bids_n_auction
  import bids_n_auction_pkg::*;
#(
  parameter int unsigned N             = 3,
  parameter int unsigned BID_W         = 16,
  parameter int unsigned BAL_W         = 32,
  parameter int unsigned TIE_MODE      = 0,
  parameter int unsigned TIMER_DEFAULT = 15
) (
  input logic             clk,
  input logic             reset_n,
  bids_n_auction_if.slave bus
);

  localparam bit TieLowest = (TIE_MODE != 0);

  state_e             state_q, state_d;
  logic [N-1:0]       mask_q, mask_d;
  logic [BAL_W-1:0]   timer_q, timer_d;
  logic [BAL_W-1:0]   cost_q, cost_d;
  logic [BAL_W-1:0]   key_q, key_d;
  logic [BAL_W-1:0]   cnt_q, cnt_d;
  logic [BID_W-1:0]   cur_q [N];
  logic [BID_W-1:0]   cur_d [N];
  logic [BAL_W-1:0]   bal_q [N];
  logic [BAL_W-1:0]   bal_d [N];

  logic [N-1:0]       ack_q, ack_d;
  logic [N-1:0]       win_q, win_d;
  logic [2*N-1:0]     b_err_q, b_err_d;
  logic [2:0]         err_q, err_d;
  logic               ready_q, ready_d;
  logic               round_over_q, round_over_d;
  logic [BID_W-1:0]   max_bid_q, max_bid_d;

  // Per-bidder results of processing this cycle as a round cycle.
  logic [BID_W-1:0]   cur_rnd [N];
  logic [BAL_W-1:0]   bal_rnd [N];
  logic [N*BID_W-1:0] cur_rnd_flat;
  logic [N-1:0]       ack_rnd;
  logic [2*N-1:0]     berr_rnd;

  logic [BID_W-1:0]   sel_max;
  logic [N-1:0]       sel_oh;
  logic               sel_dup;
  logic               sel_any;
  logic [N*BAL_W-1:0] bal_flat;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StUnlocked;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUnlocked: if (bus.C_op == OpLock) state_d = StLocked;
      StLocked: begin
        if (bus.C_start) begin
          state_d = StRound;
        end else if (bus.C_op == OpUnlock) begin
          state_d = (bus.C_data == key_q) ? StUnlocked : StLockout;
        end
      end
      StLockout: if (cnt_q <= BAL_W'(1)) state_d = StLocked;
      StRound:   if (!bus.C_start) state_d = StResult;
      StResult:  state_d = StLocked;
      default:   state_d = StUnlocked;
    endcase
  end

  // Bid/retract handling for every bidder in parallel, as if in a round.
  always_comb begin
    cur_rnd_flat = '0;
    ack_rnd      = '0;
    berr_rnd     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cur_rnd[i] = cur_q[i];
      bal_rnd[i] = bal_q[i];
      if (bus.retract[i]) begin
        cur_rnd[i] = '0;
        ack_rnd[i] = 1'b1;
      end else if (bus.bid[i]) begin
        if (!mask_q[i]) begin
          berr_rnd[2*i +: 2] = BErrMasked;
        end else if ({1'b0, bal_q[i]} >= ((BAL_W+1)'(bus.bid_amt[i*BID_W +: BID_W]) +
                                          (BAL_W+1)'(cost_q))) begin
          cur_rnd[i] = bus.bid_amt[i*BID_W +: BID_W];
          bal_rnd[i] = bal_q[i] - cost_q;
          ack_rnd[i] = 1'b1;
        end else begin
          // A failed attempt is still charged, but never below zero.
          berr_rnd[2*i +: 2] = BErrFunds;
          bal_rnd[i] = (bal_q[i] > cost_q) ? (bal_q[i] - cost_q) : '0;
        end
      end
      cur_rnd_flat[i*BID_W +: BID_W] = cur_rnd[i];
    end
  end

  // Result uses the bids including the closing cycle's activity.
  bids_n_auction_max_select #(
    .N (N),
    .W (BID_W)
  ) u_max_select (
    .vals_i   (cur_rnd_flat),
    .max_o    (sel_max),
    .onehot_o (sel_oh),
    .dup_o    (sel_dup),
    .any_o    (sel_any)
  );

  // Output and datapath next values.
  always_comb begin
    mask_d       = mask_q;
    timer_d      = timer_q;
    cost_d       = cost_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    bal_d        = bal_q;
    ack_d        = '0;
    b_err_d      = '0;
    err_d        = ErrNone;
    win_d        = win_q;
    max_bid_d    = max_bid_q;
    round_over_d = 1'b0;
    ready_d      = (state_d == StUnlocked) || (state_d == StLocked);

    unique case (state_q)
      StUnlocked: begin
        case (bus.C_op)
          OpNoOp:   ;
          OpUnlock: err_d = ErrAlreadyUnlock;
          OpLock:   key_d = bus.C_data;
          OpLoadBal: begin
            if (32'(bus.C_idx) >= N) begin
              err_d = ErrBadOp;
            end else begin
              for (int unsigned i = 0; i < N; i++) begin
                if (bus.C_idx == 4'(i)) bal_d[i] = bus.C_data;
              end
            end
          end
          OpSetMask:   mask_d  = bus.C_data[N-1:0];
          OpSetTimer:  timer_d = (bus.C_data == '0) ? BAL_W'(1) : bus.C_data;
          OpBidCharge: cost_d  = bus.C_data;
          default:     err_d   = ErrBadOp;
        endcase
        // Starting a round while unlocked overrides any op error; the op still runs.
        if (bus.C_start) err_d = ErrStartUnlocked;
      end
      StLocked: begin
        if (bus.C_start) begin
          for (int unsigned i = 0; i < N; i++) cur_d[i] = '0;
          win_d = '0;
        end else if (bus.C_op == OpUnlock) begin
          if (bus.C_data != key_q) begin
            err_d = ErrBadKey;
            cnt_d = timer_q;
          end
        end else if (bus.C_op != OpNoOp) begin
          err_d = ErrBadOp;
        end
      end
      StLockout: cnt_d = cnt_q - BAL_W'(1);
      StRound: begin
        cur_d   = cur_rnd;
        bal_d   = bal_rnd;
        ack_d   = ack_rnd;
        b_err_d = berr_rnd;
        if (!bus.C_start) begin
          round_over_d = 1'b1;
          if (sel_any && (!sel_dup || TieLowest)) begin
            win_d     = sel_oh;
            max_bid_d = sel_max;
            for (int unsigned i = 0; i < N; i++) begin
              if (sel_oh[i]) begin
                bal_d[i] = (bal_rnd[i] >= BAL_W'(sel_max)) ? (bal_rnd[i] - BAL_W'(sel_max))
                                                           : '0;
              end
            end
          end else begin
            win_d     = '0;
            max_bid_d = '0;
            if (sel_dup) err_d = ErrDupTop;
          end
        end
      end
      StResult: ;
      default: ;
    endcase

    // Bidder activity outside a round is refused.
    if (state_q != StRound) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.bid[i] || bus.retract[i]) b_err_d[2*i +: 2] = BErrInactive;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '1;
      timer_q      <= BAL_W'(TIMER_DEFAULT);
      cost_q       <= BAL_W'(1);
      key_q        <= '0;
      cnt_q        <= '0;
      cur_q        <= '{default: '0};
      bal_q        <= '{default: '0};
      ack_q        <= '0;
      win_q        <= '0;
      b_err_q      <= '0;
      err_q        <= ErrNone;
      ready_q      <= 1'b0;
      round_over_q <= 1'b0;
      max_bid_q    <= '0;
    end else begin
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      cost_q       <= cost_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      bal_q        <= bal_d;
      ack_q        <= ack_d;
      win_q        <= win_d;
      b_err_q      <= b_err_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      round_over_q <= round_over_d;
      max_bid_q    <= max_bid_d;
    end
  end

  // Flatten balances onto the bus.
  always_comb begin
    bal_flat = '0;
    for (int unsigned i = 0; i < N; i++) bal_flat[i*BAL_W +: BAL_W] = bal_q[i];
  end

  assign bus.ack       = ack_q;
  assign bus.win       = win_q;
  assign bus.b_err     = b_err_q;
  assign bus.balance   = bal_flat;
  assign bus.err       = err_q;
  assign bus.ready     = ready_q;
  assign bus.roundOver = round_over_q;
  assign bus.maxBid    = max_bid_q;

endmodule

// File: doc/bids_n_auction.md
Name: bids_n_auction

Overview:
- Parametrised N-bidder sealed-bid auction controller; next generation of the 3-bidder bids22 block.
- Generalises bidder count, bid/balance widths and tie handling.
- Adds: winner balance debit, bad-key lockout timer, and per-round retract with acknowledge.
- Sits between the auction host (C_* control port) and N bidder agents.

Parameters:
- N, 3, number of bidders (2..16).
- BID_W, 16, bid amount width.
- BAL_W, 32, balance, key, timer and cost width.
- TIE_MODE, 0, equal top bids: 0 = no winner with err DUP; 1 = lowest index wins.
- TIMER_DEFAULT, 15, lockout cycles after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- bid  in  N  per-bidder bid request pulse.
- retract  in  N  per-bidder retract pulse.
- bid_amt  in  N*BID_W  flattened bid amounts; bidder i at [i*BID_W +: BID_W].
- C_start  in  1  round active level.
- C_op  in  4  control opcode.
- C_data  in  BAL_W  control operand.
- C_idx  in  4  bidder index for LoadBal.
- ack  out  N  per-bidder accept pulse.
- win  out  N  one-hot winner, held.
- b_err  out  N*2  per-bidder error pulse.
- balance  out  N*BAL_W  current balances.
- err  out  3  controller error pulse.
- ready  out  1  1 when accepting C_op.
- roundOver  out  1  result pulse.
- maxBid  out  BID_W  winning amount, held.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - State UNLOCKED; mask all ones; timer TIMER_DEFAULT; bid_cost 1; key 0; cur bids 0.
  - ready goes 1 the first cycle after release.
- Timing:
  - All outputs are registered.
  - ack, b_err, err and roundOver are 1-cycle pulses, one cycle after the causing input.
- Opcodes (bids_pkg): NoOp 0, Unlock 1, Lock 2, LoadBal 3, SetMask 4, SetTimer 5, BidCharge 6; 7..15 invalid.
- err codes: 000 none, 001 bad key, 010 already unlocked, 011 C_start while unlocked, 100 invalid op, 101 duplicate top bid.
- b_err codes: 00 none, 01 round inactive, 10 insufficient funds, 11 masked.
- UNLOCKED:
  - LoadBal: balance[C_idx] = C_data. C_idx >= N gives err 100 and no write.
  - SetMask: mask = C_data[N-1:0].
  - SetTimer: timer = C_data; a value of 0 is stored as 1.
  - BidCharge: bid_cost = C_data.
  - Unlock gives err 010.
  - Lock: key = C_data, go to LOCKED.
  - C_start=1 gives err 011 and the state is unchanged. err 011 takes priority over any same-cycle op error; the op itself still executes.
- LOCKED:
  - C_start=1: go to ROUND; clear cur bids and win; maxBid holds.
  - Unlock with C_data==key: go to UNLOCKED.
  - Unlock with a mismatched key: err 001, go to LOCKOUT.
  - Any other non-NoOp: err 100.
  - bid or retract asserted: b_err 01.
- LOCKOUT:
  - ready=0; down-counter loaded with timer on entry.
  - Return to LOCKED after exactly timer cycles.
  - C_op is ignored with no err; bid/retract give b_err 01.
- ROUND, per bidder i, each cycle:
  - retract[i] (wins over bid[i]): cur[i]=0, ack[i], no charge.
  - bid[i] with mask[i]=0: b_err 11, no charge, cur unchanged.
  - bid[i] with balance >= bid_amt + bid_cost (BAL_W+1-bit compare, no wrap): cur[i]=bid_amt, balance -= bid_cost, ack[i].
  - Otherwise: b_err 10, cur unchanged, balance -= bid_cost, saturating at 0.
  - All N bidders are processed in the same cycle.
  - C_start falling gives RESULT; bid/retract in that same cycle are processed in ROUND.
- RESULT (1 cycle), then LOCKED:
  - roundOver pulses.
  - Take the maximum cur; a bid of 0 does not count.
  - No nonzero bid: win=0, maxBid=0.
  - Unique max: win[i]=1, maxBid=cur[i], balance[i] -= cur[i].
  - Tie at max with TIE_MODE 0: err 101, win=0, maxBid=0.
  - Tie at max with TIE_MODE 1: the lowest index wins.
- Reset mid-round: all state is discarded, including balances.

Decomposition:
- bids_pkg holds: opcode enum, state enum (UNLOCKED, LOCKED, LOCKOUT, ROUND, RESULT), err and b_err localparams.
- Sub-module bids_max_select: combinational argmax over N×BID_W.
  - Outputs: max value, one-hot lowest-index max, dup flag (more than one nonzero entry equals the max), any_nonzero.

Test Plan:
- N=3, TIE_MODE=0. LoadBal idx0..2 = 100; Lock key 0xABCD; C_start 1; bids 30/50/40, cost 1; C_start 0 -> ack 3'b111; roundOver; win 3'b010; maxBid 50; balances 99/49/99.
- Locked. Unlock C_data 0x1234, timer 4 -> err 001; ready 0 for exactly 4 cycles. Then Unlock 0xABCD -> UNLOCKED, no err.
- Balance 10, cost 1, bid 10 -> b_err 10, no ack, balance 9. Repeat with balance 0 -> balance stays 0.
- mask 3'b101, bidder1 bids -> b_err 11, balance unchanged. Bidder0 bids 20 then retracts; round ends -> bidder0 not winner; win from others only.
- Bids 60/60/10, TIE_MODE=0 -> err 101, win 0. Same with TIE_MODE=1 -> win 3'b001, maxBid 60.
- reset_n low mid-ROUND -> outputs 0 immediately. After release: ready 1 next cycle, state UNLOCKED, C_start=1 -> err 011.
